// File: rtl/mul_err_sweep_monitor.sv
// rtl/mul_err_sweep_monitor.sv - exhaustive operand sweep and error metrics for an approximate multiplier
//
// Drives every operand pair into an external combinational approximate
// multiplier and compares its product with the exact product. When a sweep
// finishes, the error metrics are held and done is raised.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        single-cycle sweep request, honoured only in IDLE/DONE
//   op_a, op_b   registered operands to the multiplier
//   approx_in    multiplier product for the current op_a/op_b
//   busy         high while sweeping or draining the pipeline
//   done         high once a sweep is complete, until the next start or rst
//   err_count    number of operand pairs where approx_in != exact
//   max_abs_err  largest |approx - exact|
//   sum_abs_err  sum of |approx - exact| over the sweep
//   worst_a/b    operands at the first occurrence of max_abs_err
module mul_err_sweep_monitor #(
    parameter int W_IN = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [W_IN-1:0]        op_a,
    output logic [W_IN-1:0]        op_b,
    input  logic [2*W_IN-1:0]      approx_in,
    output logic                   busy,
    output logic                   done,
    output logic [2*W_IN:0]        err_count,
    output logic [2*W_IN-1:0]      max_abs_err,
    output logic [4*W_IN-1:0]      sum_abs_err,
    output logic [W_IN-1:0]        worst_a,
    output logic [W_IN-1:0]        worst_b
);

    localparam int W_OUT = 2 * W_IN;
    localparam int W_IDX = 2 * W_IN;

    localparam logic [W_IDX-1:0] IDX_LAST = {W_IDX{1'b1}};
    localparam logic [W_IDX-1:0] IDX_ONE  = {{(W_IDX-1){1'b0}}, 1'b1};
    localparam logic [2*W_IN:0]  ERR_ONE  = {{(2*W_IN){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   drain_q;          // set once the first DRAIN cycle has elapsed
    logic   start_accept;

    logic [W_IDX-1:0] idx_q;

    // Stage-1 capture of the multiplier result and its reference.
    logic             valid1_q;
    logic [W_OUT-1:0] approx1_q;
    logic [W_OUT-1:0] exact1_q;
    logic [W_IN-1:0]  a1_q;
    logic [W_IN-1:0]  b1_q;

    logic [W_OUT-1:0] exact_now;
    logic [W_OUT-1:0] abs_diff;

    // Operands are slices of the registered sweep index.
    assign op_a = idx_q[W_IN-1:0];
    assign op_b = idx_q[W_IDX-1:W_IN];

    assign exact_now = {{W_IN{1'b0}}, op_a} * {{W_IN{1'b0}}, op_b};

    always_comb begin
        abs_diff = '0;
        if (approx1_q >= exact1_q) begin
            abs_diff = approx1_q - exact1_q;
        end else begin
            abs_diff = exact1_q - approx1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == S_DRAIN);
        end
    end

    always_comb begin
        state_d      = state_q;
        start_accept = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_d      = S_SWEEP;
                end
            end
            S_SWEEP: begin
                busy = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Two cycles let the final pair pass both pipeline stages.
                if (drain_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    start_accept = 1'b1;
                    state_d      = S_SWEEP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sweep index: cleared on an accepted start, counts through SWEEP and
    // wraps to zero on the transition into DRAIN, then holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else if (start_accept) begin
            idx_q <= '0;
        end else if (state_q == S_SWEEP) begin
            idx_q <= idx_q + IDX_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1_q  <= 1'b0;
            approx1_q <= '0;
            exact1_q  <= '0;
            a1_q      <= '0;
            b1_q      <= '0;
        end else begin
            valid1_q  <= (state_q == S_SWEEP);
            approx1_q <= approx_in;
            exact1_q  <= exact_now;
            a1_q      <= op_a;
            b1_q      <= op_b;
        end
    end

    // Stage-2 accumulation. Strict greater-than keeps the earliest worst pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count   <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
            worst_a     <= '0;
            worst_b     <= '0;
        end else if (start_accept) begin
            err_count   <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
            worst_a     <= '0;
            worst_b     <= '0;
        end else if (valid1_q) begin
            if (abs_diff != '0) begin
                err_count <= err_count + ERR_ONE;
            end
            sum_abs_err <= sum_abs_err + {{(2*W_IN){1'b0}}, abs_diff};
            if (abs_diff > max_abs_err) begin
                max_abs_err <= abs_diff;
                worst_a     <= a1_q;
                worst_b     <= b1_q;
            end
        end
    end

endmodule

// File: doc/mul_err_sweep_monitor.md
Name: mul_err_sweep_monitor

Overview:
- Sequential error-evaluation harness stage for the 6x6 approximate multiplier netlists.
- Upstream role: generates an exhaustive operand sweep that drives the combinational approximate multiplier.
- Downstream role: captures the multiplier's 12-bit product and compares it against an internally computed exact product.
- Accumulates error metrics (error count, maximum absolute error, sum of absolute errors, worst-case operands) for a whole sweep and reports them with a done flag.

Parameters:
- W_IN, 6, width of each unsigned operand.
- W_OUT, 2*W_IN (derived localparam, not overridable), product width.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle request to begin a sweep.
- op_a  output  W_IN  operand A to the multiplier, registered.
- op_b  output  W_IN  operand B to the multiplier, registered.
- approx_in  input  W_OUT  multiplier product, combinational function of op_a/op_b in the same cycle.
- busy  output  1  high in SWEEP and DRAIN.
- done  output  1  high in DONE.
- err_count  output  2*W_IN+1  number of operand pairs with approx_in != exact.
- max_abs_err  output  W_OUT  largest |approx - exact|.
- sum_abs_err  output  W_OUT+2*W_IN  sum of |approx - exact| over the sweep.
- worst_a  output  W_IN  operand A at the first occurrence of max_abs_err.
- worst_b  output  W_IN  operand B at the first occurrence of max_abs_err.

Behaviour:
- Reset (async, any state): FSM=IDLE; index, op_a, op_b, all metrics, worst_a/b, pipeline valids = 0; busy=0, done=0.
- Sweep index i is 2*W_IN bits wide. Mapping: op_a = i[W_IN-1:0], op_b = i[2*W_IN-1:W_IN].
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE/DONE + start:
  - go to SWEEP.
  - clear all metrics, worst_a/b and index to 0 on that edge.
  - done drops.
- start in SWEEP or DRAIN is ignored.
- SWEEP:
  - index increments by 1 each cycle.
  - At index = 2^(2*W_IN)-1, go to DRAIN on the next edge.
  - Index wraps to 0; op_a/op_b then hold 0.
- Pipeline stage 1 (edge after operands are driven):
  - register approx_in, exact = op_a*op_b (full W_OUT bits, unsigned), op_a, op_b, valid1.
  - valid1 = 1 only for edges sampling SWEEP cycles.
- Pipeline stage 2 (next edge, when valid1):
  - d = |approx - exact| (unsigned magnitude, both orderings handled).
  - if d != 0: err_count += 1.
  - sum_abs_err += d.
  - if d > max_abs_err (strictly): max_abs_err = d, worst_a/b = stage-1 operands.
  - Ties keep the earlier pair.
- DRAIN: lasts exactly 2 cycles, then DONE.
- Timing, with start sampled at edge E0:
  - operand i is driven after E0+i.
  - last accumulate occurs at E0+2^(2*W_IN)+1.
  - done rises after E0+2^(2*W_IN)+2 (E0+4098 for W_IN=6).
- DONE: metrics held stable; done held high until the next start or rst.
- No overflow is possible: err_count max 2^(2W), sum max < 2^W_OUT * 2^(2W).
- Mean error distance = sum_abs_err >> 2*W_IN; this is computed externally.
- rst mid-sweep aborts immediately. No partial results are retained; the next start performs a full fresh sweep.

Test Plan:
- Exact stub (approx_in = op_a*op_b), start pulse:
  - busy rises next cycle; done rises 4098 cycles after start.
  - err_count=0, max_abs_err=0, sum_abs_err=0, worst_a=worst_b=0.
- Zero stub (approx_in = 0):
  - err_count=3969, max_abs_err=3969, worst_a=63, worst_b=63, sum_abs_err=4064256.
- Bit-0-flip stub (approx_in = exact ^ 1), checks tie rule:
  - err_count=4096, max_abs_err=1, sum_abs_err=4096, worst_a=0, worst_b=0.
- Overshoot stub (approx_in = exact+5 when op_a=7 and op_b=9, else exact):
  - err_count=1, max_abs_err=5, sum_abs_err=5, worst_a=7, worst_b=9.
- start re-pulsed at cycles 50 and 4097 during busy:
  - no effect; done still at cycle 4098.
  - start again in DONE clears metrics and the sweep repeats with identical results.
- rst asserted asynchronously mid-cycle at cycle 100 of a sweep:
  - all outputs 0 immediately, FSM IDLE.
  - after rst release, a start produces the full correct result from scenario 2.
